// File: rtl/axi_lite_host_arbiter_pkg.sv
// Shared types and bus widths for the AXI-Lite host port arbiter.
// Latency: n/a (declarations only).  Backpressure: n/a.
package axi_lite_arb_pkg;

    localparam int ADDR_W = 32;
    localparam int DATA_W = 32;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_e;

endpackage

// File: rtl/axi_lite_host_arbiter_if.sv
// Requester-side and host-side signals of the arbiter; master = arbiter view.
// Latency: n/a (wiring only).  Backpressure: requesters hold req until done.
interface axi_lite_host_arbiter_if #(
    parameter int NUM_REQ = 4
);
    import axi_lite_arb_pkg::*;

    logic [NUM_REQ-1:0]        req;
    logic [NUM_REQ*ADDR_W-1:0] req_addr;
    logic [NUM_REQ*DATA_W-1:0] req_wdata;
    logic [NUM_REQ-1:0]        req_write;
    logic [NUM_REQ-1:0]        gnt;
    logic [NUM_REQ-1:0]        done;
    logic [DATA_W-1:0]         done_rdata;
    logic                      transfer;
    logic                      ready;
    logic [ADDR_W-1:0]         addr;
    logic [DATA_W-1:0]         wdata;
    logic                      write;
    logic [DATA_W-1:0]         rdata;

    modport master (
        input  req, req_addr, req_wdata, req_write, ready, rdata,
        output gnt, done, done_rdata, transfer, addr, wdata, write
    );

    modport slave (
        output req, req_addr, req_wdata, req_write, ready, rdata,
        input  gnt, done, done_rdata, transfer, addr, wdata, write
    );

endinterface

// File: rtl/axi_lite_host_arbiter_rr_picker.sv
// Picks the first set request searching upward from ptr with wrap (ARB_FIXED_PRIO_EN: from 0).
// Latency: combinational.  Backpressure: none; caller decides when to accept.
module rr_picker #(
    parameter int NUM_REQ = 4,
    parameter int IDX_W   = $clog2(NUM_REQ)
) (
    input  logic [NUM_REQ-1:0] req,
    input  logic [IDX_W-1:0]   ptr,
    output logic [NUM_REQ-1:0] gnt,
    output logic [IDX_W-1:0]   idx,
    output logic               any
);

    logic [IDX_W-1:0] ptr_eff;

`ifdef ARB_FIXED_PRIO_EN
    assign ptr_eff = '0;
`else
    assign ptr_eff = ptr;
`endif

    always_comb begin
        int j;
        j   = 0;
        gnt = '0;
        idx = '0;
        any = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            j = int'(ptr_eff) + k;
            if (j >= NUM_REQ) j = j - NUM_REQ;
            if (!any && req[IDX_W'(j)]) begin
                any              = 1'b1;
                idx              = IDX_W'(j);
                gnt[IDX_W'(j)]   = 1'b1;
            end
        end
    end

endmodule

// File: rtl/axi_lite_host_arbiter.sv
// Shares one AXI-Lite host port among NUM_REQ requesters, round-robin (ARB_FIXED_PRIO_EN: fixed, index 0 first).
// Latency: req -> transfer 2 cycles, ready -> done 1 cycle, 1 idle cycle between grants.
// Backpressure: one transaction outstanding; requesters hold req until their done pulse.
module axi_lite_host_arbiter
    import axi_lite_arb_pkg::*;
#(
    parameter int NUM_REQ = 4
) (
    input  logic                    ACLK,
    input  logic                    ARESET,
    axi_lite_host_arbiter_if.master bus
);

    localparam int IDX_W = $clog2(NUM_REQ);

    arb_state_e state_q, state_d;

    logic [NUM_REQ-1:0] pick_gnt;
    logic [IDX_W-1:0]   pick_idx;
    logic               pick_any;
    logic [IDX_W-1:0]   rr_ptr;

    logic load_grant, capture, finish;

    logic [ADDR_W-1:0]  addr_sel;
    logic [DATA_W-1:0]  wdata_sel;
    logic               write_sel;

    logic [NUM_REQ-1:0] gnt_q, done_q;
    logic [DATA_W-1:0]  done_rdata_q, wdata_q;
    logic [ADDR_W-1:0]  addr_q;
    logic               transfer_q, write_q;

    rr_picker #(
        .NUM_REQ (NUM_REQ),
        .IDX_W   (IDX_W)
    ) u_picker (
        .req (bus.req),
        .ptr (rr_ptr),
        .gnt (pick_gnt),
        .idx (pick_idx),
        .any (pick_any)
    );

    always_comb begin
        addr_sel  = '0;
        wdata_sel = '0;
        write_sel = 1'b0;
        for (int k = 0; k < NUM_REQ; k++) begin
            if (pick_gnt[k]) begin
                addr_sel  = bus.req_addr[k*ADDR_W +: ADDR_W];
                wdata_sel = bus.req_wdata[k*DATA_W +: DATA_W];
                write_sel = bus.req_write[k];
            end
        end
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // ready is only honoured in WAIT, so an early or stray pulse is dropped.
    always_comb begin
        state_d    = state_q;
        load_grant = 1'b0;
        capture    = 1'b0;
        finish     = 1'b0;
        case (state_q)
            IDLE:  if (pick_any) begin load_grant = 1'b1; state_d = ISSUE; end
            ISSUE: state_d = WAIT;
            WAIT:  if (bus.ready) begin capture = 1'b1; state_d = DONE; end
            DONE:  begin finish = 1'b1; state_d = IDLE; end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            gnt_q        <= '0;
            done_q       <= '0;
            done_rdata_q <= '0;
            transfer_q   <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            write_q      <= 1'b0;
        end else begin
            transfer_q <= (state_q == ISSUE);
            done_q     <= capture ? gnt_q : '0;
            if (load_grant) begin
                gnt_q   <= pick_gnt;
                addr_q  <= addr_sel;
                wdata_q <= wdata_sel;
                write_q <= write_sel;
            end
            if (capture) done_rdata_q <= bus.rdata;
            if (finish)  gnt_q        <= '0;
        end
    end

`ifdef ARB_FIXED_PRIO_EN
    assign rr_ptr = '0;
`else
    logic [IDX_W-1:0] owner_q;

    // Last owner drops to lowest priority for the next arbitration.
    always_ff @(posedge ACLK) begin
        if (ARESET) begin
            owner_q <= '0;
            rr_ptr  <= '0;
        end else begin
            if (load_grant) owner_q <= pick_idx;
            if (finish) rr_ptr <= (owner_q == IDX_W'(NUM_REQ-1)) ? '0 : owner_q + 1'b1;
        end
    end
`endif

    assign bus.gnt        = gnt_q;
    assign bus.done       = done_q;
    assign bus.done_rdata = done_rdata_q;
    assign bus.transfer   = transfer_q;
    assign bus.addr       = addr_q;
    assign bus.wdata      = wdata_q;
    assign bus.write      = write_q;

endmodule

// File: tb/tb_axi_lite_host_arbiter.sv
// Bench for axi_lite_host_arbiter: directed scenarios plus randomized traffic against a
// transaction-level model (cycle of grant, transfer, done predicted from the arbitration rules).
module tb_axi_lite_host_arbiter;

    localparam int N = 4;

    logic ACLK   = 1'b0;
    logic ARESET = 1'b1;
    always #5 ACLK = ~ACLK;

    axi_lite_host_arbiter_if #(.NUM_REQ(N)) bus();

    axi_lite_host_arbiter #(.NUM_REQ(N)) dut (
        .ACLK   (ACLK),
        .ARESET (ARESET),
        .bus    (bus.master)
    );

    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    // reference model state
    bit          busy = 1'b0;
    int          owner = 0, g_cyc = 0, done_at = -1, idle_since = 0, ptr = 0;
    logic [31:0] last_rdata = '0, m_addr = '0, m_wdata = '0;
    logic        m_write = 1'b0;
    int          grant_q[$];
    int          grant_cnt = 0, comp_cnt = 0, xfer_seen = 0, dut_done_cnt = 0;

    // stimulus state
    logic [31:0] ra[N];
    logic [31:0] rd[N];
    logic        rwr[N];
    bit          abandoned[N];
    bit          rand_mode = 1'b0, hold_all = 1'b0, use_fix = 1'b0;
    int          host_delay = 0, ready_cyc = -1;
    logic [31:0] host_rdata_fix = '0;

    task automatic chk(string tag, logic [31:0] obs, logic [31:0] exp);
        total++;
        if (obs !== exp) begin
            bad++;
            $display("FAIL %s: got %h want %h (cycle %0d)", tag, obs, exp, cyc);
        end
    endtask

    function automatic int pick(logic [N-1:0] r, int p);
        for (int k = 0; k < N; k++)
            if (r[(p + k) % N]) return (p + k) % N;
        return -1;
    endfunction

    task automatic set_req(int i, logic [31:0] a, logic [31:0] d, logic w);
        ra[i] = a; rd[i] = d; rwr[i] = w;
        bus.req_addr[32*i +: 32]  = a;
        bus.req_wdata[32*i +: 32] = d;
        bus.req_write[i]          = w;
        bus.req[i]                = 1'b1;
    endtask

    // Runs at each falling edge before new inputs are applied; current inputs are the ones
    // the DUT sampled on the last rising edge.
    task automatic monitor();
        logic [N-1:0] r, exp_gnt, exp_done;
        logic         exp_xfer;
        r        = bus.req;
        exp_done = '0;
        if (ARESET) begin
            chk("rst_gnt",        32'(bus.gnt), 0);
            chk("rst_done",       32'(bus.done), 0);
            chk("rst_transfer",   32'(bus.transfer), 0);
            chk("rst_write",      32'(bus.write), 0);
            chk("rst_addr",       bus.addr, 0);
            chk("rst_wdata",      bus.wdata, 0);
            chk("rst_done_rdata", bus.done_rdata, 0);
            busy = 1'b0; ptr = 0; last_rdata = '0; idle_since = cyc; done_at = -1;
            return;
        end
        if (busy && done_at == cyc - 1) begin
            busy = 1'b0;
            idle_since = cyc;
            comp_cnt++;
`ifdef ARB_FIXED_PRIO_EN
            ptr = 0;
`else
            ptr = (owner + 1) % N;
`endif
        end
        if (!busy && cyc - 1 >= idle_since && r != '0) begin
            owner = pick(r, ptr);
            busy = 1'b1; g_cyc = cyc; done_at = -1;
            m_addr = ra[owner]; m_wdata = rd[owner]; m_write = rwr[owner];
            grant_q.push_back(owner);
            grant_cnt++;
        end
        if (busy && done_at < 0 && cyc - 1 >= g_cyc + 1 && bus.ready) begin
            done_at = cyc;
            exp_done = N'(1) << owner;
            last_rdata = bus.rdata;
        end
        exp_gnt  = busy ? (N'(1) << owner) : '0;
        exp_xfer = busy && (cyc == g_cyc + 1);
        chk("gnt",        32'(bus.gnt), 32'(exp_gnt));
        chk("transfer",   32'(bus.transfer), 32'(exp_xfer));
        chk("done",       32'(bus.done), 32'(exp_done));
        chk("done_rdata", bus.done_rdata, last_rdata);
        if (busy) begin
            chk("addr",  bus.addr, m_addr);
            chk("wdata", bus.wdata, m_wdata);
            chk("write", 32'(bus.write), 32'(m_write));
        end
        if (bus.transfer) xfer_seen++;
        if (bus.done != '0) dut_done_cnt++;
    endtask

    task automatic stimulus();
        bus.ready = 1'b0;
        if (bus.transfer)
            ready_cyc = cyc + ((host_delay > 0) ? host_delay : int'($urandom_range(4, 1)));
        if (cyc == ready_cyc) begin
            bus.ready = 1'b1;
            bus.rdata = use_fix ? host_rdata_fix : $urandom;
        end else if (rand_mode && !busy && $urandom_range(7, 0) == 0) begin
            bus.ready = 1'b1;
            bus.rdata = $urandom;
        end
        for (int i = 0; i < N; i++) begin
            if (bus.done[i]) begin
                if (!hold_all) bus.req[i] = 1'b0;
                abandoned[i] = 1'b0;
            end else if (rand_mode) begin
                if (!bus.req[i] && !abandoned[i] && $urandom_range(2, 0) == 0)
                    set_req(i, $urandom, $urandom, 1'($urandom_range(1, 0)));
                else if (bus.req[i] && bus.gnt[i] && $urandom_range(19, 0) == 0) begin
                    bus.req[i]   = 1'b0;
                    abandoned[i] = 1'b1;
                end
            end
        end
    endtask

    task automatic step();
        @(negedge ACLK);
        cyc++;
        monitor();
        stimulus();
    endtask

    task automatic run_cycles(int n);
        for (int k = 0; k < n; k++) step();
    endtask

    task automatic run_until_grants(int n, int budget, string tag);
        int k;
        k = 0;
        while (grant_cnt < n && k < budget) begin step(); k++; end
        chk(tag, grant_cnt, n);
    endtask

    task automatic run_until_idle(int budget, string tag);
        int k;
        k = 0;
        while ((busy || bus.req != '0) && k < budget) begin step(); k++; end
        chk(tag, 32'(busy), 0);
        step();
        step();
    endtask

    task automatic do_reset();
        ARESET  = 1'b1;
        bus.req = '0;
        for (int i = 0; i < N; i++) abandoned[i] = 1'b0;
        ready_cyc = -1;
        run_cycles(2);
        ARESET = 1'b0;
    endtask

    initial begin
        int g0, d0, x0, k;
        bus.req = '0; bus.req_addr = '0; bus.req_wdata = '0; bus.req_write = '0;
        bus.ready = 1'b0; bus.rdata = '0;
        for (int i = 0; i < N; i++) begin
            ra[i] = '0; rd[i] = '0; rwr[i] = 1'b0; abandoned[i] = 1'b0;
        end

        ARESET = 1'b1;
        run_cycles(3);
        ARESET = 1'b0;

        // single read from requester 2
        host_delay = 3; use_fix = 1'b1; host_rdata_fix = 32'hCAFE_0001;
        g0 = grant_cnt; x0 = xfer_seen; d0 = dut_done_cnt;
        set_req(2, 32'h4, 32'h0, 1'b0);
        run_until_grants(g0 + 1, 10, "t1_grant");
        run_until_idle(30, "t1_idle");
        chk("t1_owner", 32'(grant_q[g0]), 2);
        chk("t1_rdata", bus.done_rdata, 32'hCAFE_0001);
        chk("t1_xfers", 32'(xfer_seen - x0), 1);
        chk("t1_dones", 32'(dut_done_cnt - d0), 1);

        // single write from requester 0
        host_rdata_fix = 32'h0BAD_F00D;
        g0 = grant_cnt; d0 = dut_done_cnt;
        set_req(0, 32'h8, 32'h1234_5678, 1'b1);
        run_until_grants(g0 + 1, 10, "t2_grant");
        run_until_idle(30, "t2_idle");
        chk("t2_owner", 32'(grant_q[g0]), 0);
        chk("t2_dones", 32'(dut_done_cnt - d0), 1);

        // all requesters held continuously
        use_fix = 1'b0; host_delay = 0;
        do_reset();
        hold_all = 1'b1;
        g0 = grant_cnt;
        for (int i = 0; i < N; i++) set_req(i, 32'h100 + 32'(i), 32'hA0 + 32'(i), 1'(i % 2));
        run_until_grants(g0 + 5, 80, "t3_grants");
        for (int i = 0; i < 5; i++) begin
`ifdef ARB_FIXED_PRIO_EN
            chk("t3_order", 32'(grant_q[g0 + i]), 0);
`else
            chk("t3_order", 32'(grant_q[g0 + i]), 32'(i % N));
`endif
        end
        hold_all = 1'b0;
        bus.req = '0;
        run_until_idle(30, "t3_idle");

        // pointer at 2 after serving 1; then 1 and 3 together
        do_reset();
        g0 = grant_cnt;
        set_req(1, 32'h10, 32'h11, 1'b0);
        run_until_grants(g0 + 1, 10, "t4_first");
        run_until_idle(30, "t4_idle1");
        set_req(1, 32'h20, 32'h21, 1'b1);
        set_req(3, 32'h30, 32'h31, 1'b0);
        run_until_grants(g0 + 3, 40, "t4_grants");
        run_until_idle(30, "t4_idle2");
`ifdef ARB_FIXED_PRIO_EN
        chk("t4_second", 32'(grant_q[g0 + 1]), 1);
        chk("t4_third",  32'(grant_q[g0 + 2]), 3);
`else
        chk("t4_second", 32'(grant_q[g0 + 1]), 3);
        chk("t4_third",  32'(grant_q[g0 + 2]), 1);
`endif

        // reset while requester 1 waits on the host
        do_reset();
        host_delay = 4;
        set_req(1, 32'h40, 32'h41, 1'b0);
        k = 0;
        while (!bus.transfer && k < 10) begin step(); k++; end
        chk("t5_transfer", 32'(bus.transfer), 1);
        step();
        chk("t5_gnt_wait", 32'(bus.gnt), 32'h2);
        ARESET = 1'b1;
        bus.req = '0;
        step();
        ARESET = 1'b0;
        d0 = dut_done_cnt;
        run_cycles(6);
        chk("t5_nodone", 32'(dut_done_cnt - d0), 0);

        // requester 1 drops req while waiting; result still delivered, then 2 is served
        host_delay = 3;
        g0 = grant_cnt; d0 = dut_done_cnt;
        set_req(1, 32'h50, 32'h51, 1'b0);
        set_req(2, 32'h60, 32'h61, 1'b1);
        k = 0;
        while (!bus.transfer && k < 10) begin step(); k++; end
        chk("t6_transfer", 32'(bus.transfer), 1);
        bus.req[1] = 1'b0;
        run_until_grants(g0 + 2, 30, "t6_grants");
        run_until_idle(30, "t6_idle");
        chk("t6_first",  32'(grant_q[g0]), 1);
        chk("t6_second", 32'(grant_q[g0 + 1]), 2);
        chk("t6_dones",  32'(dut_done_cnt - d0), 2);

        // randomized traffic
        host_delay = 0;
        rand_mode  = 1'b1;
        run_cycles(3000);
        rand_mode  = 1'b0;
        run_until_idle(400, "rand_drain");
        chk("done_count", 32'(dut_done_cnt), 32'(comp_cnt));

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit reached at cycle %0d", cyc);
        $fatal(1, "watchdog");
    end

endmodule
